led_rate_divider: RTL and testbench
===================================

# led_rate_divider

Programmable rate generator that sits directly upstream of the LED chaser. It divides the 50 MHz board clock into a slow, 50 %-duty clock (`div_clk`) and a matching single-cycle enable pulse (`tick`); either one drives the chaser's stepping. The rate can be changed at runtime with speed-up, slow-down and reset-speed commands. New rates are applied only at half-period boundaries, so the output never glitches.

## Interface
- `CNT_W`, 32: width of the counter and of the half-period registers.
- `DEFAULT_HALF`, 25_000_000: half-period in clk cycles after reset or `speed_rst` (1 Hz at 50 MHz).
- `STEP`, 1_000_000: half-period change per speed command.
- `MIN_HALF`, 1_000_000: lower saturation limit. Must satisfy MIN_HALF ≥ 1.
- `MAX_HALF`, 100_000_000: upper saturation limit. Must satisfy MIN_HALF < DEFAULT_HALF < MAX_HALF < 2^CNT_W.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `en` in 1: run enable; low freezes all counting.
- `speed_up` in 1: single-cycle pulse; shorten half-period by STEP.
- `speed_dn` in 1: single-cycle pulse; lengthen half-period by STEP.
- `speed_rst` in 1: single-cycle pulse; restore DEFAULT_HALF.
- `div_clk` out 1: registered divided clock, 50 % duty.
- `tick` out 1: one-clk pulse, asserted in the cycle `div_clk` rises.
- `half_period` out CNT_W: pending (next-applied) half-period.
- `at_min` out 1: pending half-period equals MIN_HALF.
- `at_max` out 1: pending half-period equals MAX_HALF.

## Operation
**Registers**
- `cnt`: the counter.
- `half_q`: the half-period currently in use.
- `half_next`: the pending half-period.
- `div_clk`, `tick`.

**Reset values**
- cnt=0, div_clk=0, tick=0.
- half_q=half_next=DEFAULT_HALF, so half_period=DEFAULT_HALF.
- at_min=0, at_max=0.

**Counting (en=1)**
- If cnt == half_q−1: cnt←0, div_clk←~div_clk, half_q←half_next.
- Otherwise: cnt←cnt+1.

**tick**
- tick←1 exactly when the wrap sets div_clk from 0 to 1; otherwise 0.

**en=0**
- cnt, div_clk and half_q hold.
- tick←0.
- Speed commands still update half_next.

**Speed commands** (evaluated every cycle regardless of en)
- Priority: `speed_rst` > (`speed_up` xor `speed_dn`). `speed_up` and `speed_dn` asserted together cancel, so half_next holds.
- up: half_next ← max(half_next−STEP, MIN_HALF).
- dn: half_next ← min(half_next+STEP, MAX_HALF).
- Arithmetic uses CNT_W+1 bits so the result can neither underflow nor overflow before saturation.
- at_min and at_max are registered compares of the new half_next value.

**Boundary conditions**
- A command in the same cycle as a wrap: the wrap loads the old half_next. The new value takes effect at the following wrap.
- Repeated commands inside one half-period: only the last resulting half_next is applied.
- Reset mid-operation: all registers return to their reset values immediately, without waiting for a clock edge.

## Timing
- From reset release with en=1: div_clk rises at the end of clk cycle DEFAULT_HALF (counting from 1), with tick high during that following cycle.
- Output period = 2·half_q clk cycles.
- tick rate = one pulse per div_clk period.
- half_period, at_min and at_max update one clk after the command.
- The rate change appears at the next div_clk edge, so latency ≤ half_q cycles.

## Configuration
- Macro: `LED_RATE_DIVIDER_SPEED_CTRL_EN`.
- **Defined:** speed commands behave as described above.
- **Undefined:**
  - speed_up, speed_dn and speed_rst are ignored.
  - half_q=half_next=DEFAULT_HALF permanently.
  - at_min=at_max=0.
  - No speed-control logic is synthesised.
- Counting, div_clk and tick behave identically in both builds.

## Structure
**Package `led_rate_pkg`:**
- Board-clock constants: CLK_HZ = 50_000_000, DEFAULT_HALF, STEP, MIN_HALF, MAX_HALF.
- Default CNT_W.
- Typedef `spd_cmd_e` with values SPD_NONE, SPD_UP, SPD_DN, SPD_RST, produced by priority-encoding the three command inputs.

**Sub-module `led_rate_speed_ctrl`:**
- Holds half_next, the saturation logic, and at_min/at_max.
- Instantiated only under the macro.
- The top level keeps cnt, half_q, div_clk and tick.

## Test plan
All scenarios use DEFAULT_HALF=4, STEP=1, MIN_HALF=2, MAX_HALF=6.
1. **Free run.** Release reset, en=1 → div_clk rises after cycle 4 and falls after cycle 8; tick high one cycle at each rise; period 8.
2. **Deferred apply.** speed_up at cycle 2 → half_period=3 at cycle 3, but the first rise is still at cycle 4; the next half-periods are 3 cycles (fall at 7, rise at 10).
3. **Saturation.** Three speed_up pulses from 4 → half_period 3, 2, 2; at_min=1. Then five speed_dn pulses → 3, 4, 5, 6, 6; at_max=1, at_min=0.
4. **Priority.** speed_rst with speed_up at half=2 → 4. speed_up with speed_dn together at 4 → stays 4.
5. **Enable.** en=0 at cnt=2 for 10 cycles → div_clk and cnt frozen, tick=0. Restore en=1 → toggle 2 cycles later.
6. **Async reset.** rst_n low mid-period while div_clk=1 → div_clk=0, tick=0, half_period=4 without waiting for a clk edge. Build without the macro → commands have no effect and the period stays 8.

Source files
------------

// File: rtl/led_rate_pkg.sv
// Shared constants, command encoding and helper for the LED rate divider.
// The speed-command path is only built when LED_RATE_DIVIDER_SPEED_CTRL_EN is defined.
package led_rate_pkg;

   localparam int unsigned CLK_HZ            = 50_000_000;
   localparam int unsigned RATE_CNT_W        = 32;
   localparam int unsigned RATE_DEFAULT_HALF = 25_000_000;
   localparam int unsigned RATE_STEP         = 1_000_000;
   localparam int unsigned RATE_MIN_HALF     = 1_000_000;
   localparam int unsigned RATE_MAX_HALF     = 100_000_000;

   typedef enum logic [1:0] {
      SPD_NONE = 2'd0,
      SPD_UP   = 2'd1,
      SPD_DN   = 2'd2,
      SPD_RST  = 2'd3
   } spd_cmd_e;

   // Reset-speed wins; up and down together cancel each other out.
   function automatic spd_cmd_e encode_cmd(input logic up, input logic dn, input logic rst);
      spd_cmd_e cmd;
      cmd = SPD_NONE;
      if (rst) begin
         cmd = SPD_RST;
      end else if (up && !dn) begin
         cmd = SPD_UP;
      end else if (dn && !up) begin
         cmd = SPD_DN;
      end
      return cmd;
   endfunction

endpackage

// File: rtl/led_rate_divider_if.sv
// Control/status bundle between the rate divider and whoever steers the LED speed.
// The speed fields are only acted upon when LED_RATE_DIVIDER_SPEED_CTRL_EN is defined.
interface led_rate_divider_if
   import led_rate_pkg::*;
#(
   parameter int unsigned CNT_W = RATE_CNT_W
);

   logic             en;
   logic             speed_up;
   logic             speed_dn;
   logic             speed_rst;
   logic             div_clk;
   logic             tick;
   logic [CNT_W-1:0] half_period;
   logic             at_min;
   logic             at_max;

   modport master (
      output en, speed_up, speed_dn, speed_rst,
      input  div_clk, tick, half_period, at_min, at_max
   );

   modport slave (
      input  en, speed_up, speed_dn, speed_rst,
      output div_clk, tick, half_period, at_min, at_max
   );

endinterface

// File: rtl/led_rate_speed_ctrl.sv
// Pending half-period register with saturating speed-up / slow-down steps.
// Only instantiated when LED_RATE_DIVIDER_SPEED_CTRL_EN is defined.
module led_rate_speed_ctrl
   import led_rate_pkg::*;
#(
   parameter int unsigned CNT_W        = RATE_CNT_W,
   parameter int unsigned DEFAULT_HALF = RATE_DEFAULT_HALF,
   parameter int unsigned STEP         = RATE_STEP,
   parameter int unsigned MIN_HALF     = RATE_MIN_HALF,
   parameter int unsigned MAX_HALF     = RATE_MAX_HALF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             speed_up,
   input  logic             speed_dn,
   input  logic             speed_rst,
   output logic [CNT_W-1:0] half_next,
   output logic             at_min,
   output logic             at_max
);

   // One extra bit so neither the step nor the threshold sum can wrap.
   localparam logic [CNT_W:0] STEP_W = (CNT_W+1)'(STEP);
   localparam logic [CNT_W:0] MIN_W  = (CNT_W+1)'(MIN_HALF);
   localparam logic [CNT_W:0] MAX_W  = (CNT_W+1)'(MAX_HALF);
   localparam logic [CNT_W:0] DEF_W  = (CNT_W+1)'(DEFAULT_HALF);

   spd_cmd_e       cmd;
   logic [CNT_W:0] cur_w;
   logic [CNT_W:0] next_w;
   logic           unused_msb;

   assign cmd        = encode_cmd(speed_up, speed_dn, speed_rst);
   assign cur_w      = {1'b0, half_next};
   assign unused_msb = next_w[CNT_W];

   // Compute the saturated candidate half-period for this cycle's command.
   always_comb begin
      next_w = cur_w;
      case (cmd)
         SPD_RST: next_w = DEF_W;
         SPD_UP:  next_w = (cur_w < (MIN_W + STEP_W)) ? MIN_W : (cur_w - STEP_W);
         SPD_DN:  next_w = ((cur_w + STEP_W) > MAX_W) ? MAX_W : (cur_w + STEP_W);
         default: next_w = cur_w;
      endcase
   end

   // Register the pending half-period and its limit flags together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         half_next <= CNT_W'(DEFAULT_HALF);
         at_min    <= 1'b0;
         at_max    <= 1'b0;
      end else begin
         half_next <= next_w[CNT_W-1:0];
         at_min    <= (next_w == MIN_W);
         at_max    <= (next_w == MAX_W);
      end
   end

endmodule

// File: rtl/led_rate_divider.sv
// Programmable divider producing a 50 % duty div_clk and a matching tick pulse.
// Define LED_RATE_DIVIDER_SPEED_CTRL_EN to enable runtime speed commands.
module led_rate_divider
   import led_rate_pkg::*;
#(
   parameter int unsigned CNT_W        = RATE_CNT_W,
   parameter int unsigned DEFAULT_HALF = RATE_DEFAULT_HALF,
   parameter int unsigned STEP         = RATE_STEP,
   parameter int unsigned MIN_HALF     = RATE_MIN_HALF,
   parameter int unsigned MAX_HALF     = RATE_MAX_HALF
) (
   input logic                clk,
   input logic                rst_n,
   led_rate_divider_if.slave  bus
);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] half_q;
   logic [CNT_W-1:0] half_next;
   logic             div_clk_q;
   logic             tick_q;
   logic             at_min_w;
   logic             at_max_w;
   logic             wrap;

`ifdef LED_RATE_DIVIDER_SPEED_CTRL_EN
   led_rate_speed_ctrl #(
      .CNT_W        (CNT_W),
      .DEFAULT_HALF (DEFAULT_HALF),
      .STEP         (STEP),
      .MIN_HALF     (MIN_HALF),
      .MAX_HALF     (MAX_HALF)
   ) u_speed_ctrl (
      .clk       (clk),
      .rst_n     (rst_n),
      .speed_up  (bus.speed_up),
      .speed_dn  (bus.speed_dn),
      .speed_rst (bus.speed_rst),
      .half_next (half_next),
      .at_min    (at_min_w),
      .at_max    (at_max_w)
   );
`else
   logic unused_cfg;

   assign half_next  = CNT_W'(DEFAULT_HALF);
   assign at_min_w   = 1'b0;
   assign at_max_w   = 1'b0;
   assign unused_cfg = ^{bus.speed_up, bus.speed_dn, bus.speed_rst,
                         (STEP > 0), (MIN_HALF < MAX_HALF)};
`endif

   assign wrap = (cnt == (half_q - CNT_W'(1)));

   // Count out each half-period; at the end flip div_clk and adopt the pending rate.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         half_q    <= CNT_W'(DEFAULT_HALF);
         div_clk_q <= 1'b0;
         tick_q    <= 1'b0;
      end else if (bus.en) begin
         if (wrap) begin
            cnt       <= '0;
            div_clk_q <= ~div_clk_q;
            half_q    <= half_next;
            tick_q    <= ~div_clk_q;
         end else begin
            cnt       <= cnt + CNT_W'(1);
            tick_q    <= 1'b0;
         end
      end else begin
         tick_q <= 1'b0;
      end
   end

   assign bus.div_clk     = div_clk_q;
   assign bus.tick        = tick_q;
   assign bus.half_period = half_next;
   assign bus.at_min      = at_min_w;
   assign bus.at_max      = at_max_w;

endmodule

// File: tb/tb_led_rate_divider.sv
// Directed self-checking bench for led_rate_divider with a tiny rate configuration
// (DEFAULT_HALF=4, STEP=1, MIN_HALF=2, MAX_HALF=6). Expectations follow
// LED_RATE_DIVIDER_SPEED_CTRL_EN: with it, commands change the rate; without it, they are ignored.
module tb_led_rate_divider;

   localparam int unsigned CW = 8;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   led_rate_divider_if #(.CNT_W(CW)) bus();

   led_rate_divider #(
      .CNT_W        (CW),
      .DEFAULT_HALF (4),
      .STEP         (1),
      .MIN_HALF     (2),
      .MAX_HALF     (6)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected div_clk / tick after edges 1..16 of a free run at half-period 4.
   logic [1:16] exp_free_div  = 16'b0001111000011110;
   logic [1:16] exp_free_tick = 16'b0001000000010000;
   // Expected after edges 1..10 with a speed_up sampled on edge 2.
   logic [1:10] exp_def_div   = 10'b0001110001;
   logic [1:10] exp_def_tick  = 10'b0001000001;

   // Command table {up,dn,rst} with resulting half_period / at_min / at_max.
   logic [2:0] cmd_tab  [14] = '{3'b100, 3'b100, 3'b100, 3'b010, 3'b010, 3'b010, 3'b010,
                                 3'b010, 3'b100, 3'b100, 3'b100, 3'b100, 3'b101, 3'b110};
   int         half_tab [14] = '{3, 2, 2, 3, 4, 5, 6, 6, 5, 4, 3, 2, 4, 4};
   logic       min_tab  [14] = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
   logic       max_tab  [14] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
      end
   endtask

   task automatic stepClk();
      @(posedge clk);
      #1;
   endtask

   // Called just after an edge: pulse rst_n low and release before the next edge.
   task automatic applyReset();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   task automatic applyStimulus(input logic up, input logic dn, input logic rst);
      bus.speed_up  = up;
      bus.speed_dn  = dn;
      bus.speed_rst = rst;
      stepClk();
      bus.speed_up  = 1'b0;
      bus.speed_dn  = 1'b0;
      bus.speed_rst = 1'b0;
   endtask

   initial begin
      total         = 0;
      bad           = 0;
      rst_n         = 1'b0;
      bus.en        = 1'b0;
      bus.speed_up  = 1'b0;
      bus.speed_dn  = 1'b0;
      bus.speed_rst = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      $display("[TB] reset state");
      checkOutput("rst_div_clk", 32'(bus.div_clk), 32'd0);
      checkOutput("rst_tick", 32'(bus.tick), 32'd0);
      checkOutput("rst_half", 32'(bus.half_period), 32'd4);
      checkOutput("rst_at_min", 32'(bus.at_min), 32'd0);
      checkOutput("rst_at_max", 32'(bus.at_max), 32'd0);

      $display("[TB] free run");
      applyReset();
      bus.en = 1'b1;
`ifndef LED_RATE_DIVIDER_SPEED_CTRL_EN
      bus.speed_up = 1'b1;
`endif
      for (int k = 1; k <= 16; k++) begin
         stepClk();
         checkOutput($sformatf("free_div_%0d", k), 32'(bus.div_clk), 32'(exp_free_div[k]));
         checkOutput($sformatf("free_tick_%0d", k), 32'(bus.tick), 32'(exp_free_tick[k]));
`ifndef LED_RATE_DIVIDER_SPEED_CTRL_EN
         checkOutput($sformatf("free_half_%0d", k), 32'(bus.half_period), 32'd4);
         checkOutput($sformatf("free_min_%0d", k), 32'(bus.at_min), 32'd0);
`endif
      end
      bus.speed_up = 1'b0;

`ifdef LED_RATE_DIVIDER_SPEED_CTRL_EN
      $display("[TB] deferred apply");
      applyReset();
      bus.en = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         bus.speed_up = (k == 2);
         stepClk();
         checkOutput($sformatf("defer_div_%0d", k), 32'(bus.div_clk), 32'(exp_def_div[k]));
         checkOutput($sformatf("defer_tick_%0d", k), 32'(bus.tick), 32'(exp_def_tick[k]));
         if (k >= 2) begin
            checkOutput($sformatf("defer_half_%0d", k), 32'(bus.half_period), 32'd3);
         end
      end
      bus.speed_up = 1'b0;

      $display("[TB] saturation and priority");
      applyReset();
      bus.en = 1'b0;
      for (int i = 0; i < 14; i++) begin
         applyStimulus(cmd_tab[i][2], cmd_tab[i][1], cmd_tab[i][0]);
         checkOutput($sformatf("cmd_half_%0d", i), 32'(bus.half_period), 32'(half_tab[i]));
         checkOutput($sformatf("cmd_min_%0d", i), 32'(bus.at_min), 32'(min_tab[i]));
         checkOutput($sformatf("cmd_max_%0d", i), 32'(bus.at_max), 32'(max_tab[i]));
      end
`endif

      $display("[TB] enable freeze");
      applyReset();
      bus.en = 1'b1;
      stepClk();
      stepClk();
      checkOutput("en_pre_div", 32'(bus.div_clk), 32'd0);
      bus.en = 1'b0;
      for (int k = 0; k < 10; k++) begin
         stepClk();
         checkOutput($sformatf("en_hold_div_%0d", k), 32'(bus.div_clk), 32'd0);
         checkOutput($sformatf("en_hold_tick_%0d", k), 32'(bus.tick), 32'd0);
      end
      bus.en = 1'b1;
      stepClk();
      checkOutput("en_resume1_div", 32'(bus.div_clk), 32'd0);
      stepClk();
      checkOutput("en_resume2_div", 32'(bus.div_clk), 32'd1);
      checkOutput("en_resume2_tick", 32'(bus.tick), 32'd1);
      stepClk();
      checkOutput("en_resume3_tick", 32'(bus.tick), 32'd0);

      $display("[TB] async reset");
      applyReset();
      bus.en = 1'b1;
      applyStimulus(1'b0, 1'b1, 1'b0);
`ifdef LED_RATE_DIVIDER_SPEED_CTRL_EN
      checkOutput("ar_half_dn", 32'(bus.half_period), 32'd5);
`else
      checkOutput("ar_half_dn", 32'(bus.half_period), 32'd4);
`endif
      repeat (3) stepClk();
      checkOutput("ar_pre_div", 32'(bus.div_clk), 32'd1);
      checkOutput("ar_pre_tick", 32'(bus.tick), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("ar_div", 32'(bus.div_clk), 32'd0);
      checkOutput("ar_tick", 32'(bus.tick), 32'd0);
      checkOutput("ar_half", 32'(bus.half_period), 32'd4);
      checkOutput("ar_at_max", 32'(bus.at_max), 32'd0);
      rst_n = 1'b1;
      stepClk();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
